// File: rtl/alu_pkg.sv
// Shared ALU definitions: command encoding, widths and the flag-mask rule
// used by both the ALU control decoder and the result stage.
package alu_pkg;

  localparam int CMD_W   = 3;
  localparam int WIDTH_W = 32;

  localparam logic [CMD_W-1:0] CMD_ADD  = 3'd0;
  localparam logic [CMD_W-1:0] CMD_SUB  = 3'd1;
  localparam logic [CMD_W-1:0] CMD_XOR  = 3'd2;
  localparam logic [CMD_W-1:0] CMD_SLT  = 3'd3;
  localparam logic [CMD_W-1:0] CMD_AND  = 3'd4;
  localparam logic [CMD_W-1:0] CMD_NAND = 3'd5;
  localparam logic [CMD_W-1:0] CMD_NOR  = 3'd6;
  localparam logic [CMD_W-1:0] CMD_OR   = 3'd7;

  // Only the adder paths produce meaningful carry/overflow; SLT uses the
  // adder internally but its flags must not leak to the consumer.
  function automatic logic cmd_pass_flags(input logic [CMD_W-1:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

endpackage

// File: rtl/alu_stage_entry.sv
// One storage slot of the result stage: command, result and already-derived
// flags, captured on load and cleared by reset.
module alu_stage_entry
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMDW  = CMD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CMDW-1:0]  cmd_d,
  input  logic [WIDTH-1:0] result_d,
  input  logic             zero_d,
  input  logic             carry_d,
  input  logic             ovf_d,
  output logic [CMDW-1:0]  cmd_q,
  output logic [WIDTH-1:0] result_q,
  output logic             zero_q,
  output logic             carry_q,
  output logic             ovf_q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (load_i) begin
      cmd_q    <= cmd_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage: flag derivation at capture, a main/skid pair of
// entries behind a valid/ready handshake, and a sticky overflow status bit.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CMDW  = CMD_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CMDW-1:0]  in_cmd,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_carryout,
  input  logic             in_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CMDW-1:0]  out_cmd,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_carryout,
  output logic             out_overflow,
  output logic             ovf_sticky,
  input  logic             ovf_clear
);

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q;
  logic sticky_q, sticky_d;

  logic accept, drain;
  logic load_main, load_skid, main_from_skid;

  logic             cap_pass, cap_zero, cap_carry, cap_ovf;

  logic [CMDW-1:0]  skid_cmd;
  logic [WIDTH-1:0] skid_result;
  logic             skid_zero, skid_carry, skid_ovf;

  logic [CMDW-1:0]  main_cmd_d;
  logic [WIDTH-1:0] main_result_d;
  logic             main_zero_d, main_carry_d, main_ovf_d;

  // Capture: flags are derived once here so both entries hold final values.
  assign cap_pass  = cmd_pass_flags(in_cmd);
  assign cap_zero  = (in_result == '0);
  assign cap_carry = cap_pass & in_carryout;
  assign cap_ovf   = cap_pass & in_overflow;

  // in_ready_q tracks "skid empty"; gating with reset keeps it low during
  // reset yet high on the first cycle after release.
  assign in_ready = in_ready_q & ~reset;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid_q & out_ready;

  always_comb begin
    main_from_skid = drain & skid_valid_q;
    load_skid      = accept & main_valid_q & ~drain;
    load_main      = main_from_skid | (accept & (~main_valid_q | (drain & ~skid_valid_q)));

    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (drain) begin
      main_valid_d = skid_valid_q | accept;
      if (skid_valid_q) skid_valid_d = 1'b0;
    end else begin
      main_valid_d = main_valid_q | accept;
      if (load_skid) skid_valid_d = 1'b1;
    end

    // A delivered overflow beats a same-cycle clear.
    sticky_d = sticky_q;
    if (drain & out_overflow) sticky_d = 1'b1;
    else if (ovf_clear)       sticky_d = 1'b0;
  end

  always_comb begin
    if (main_from_skid) begin
      main_cmd_d    = skid_cmd;
      main_result_d = skid_result;
      main_zero_d   = skid_zero;
      main_carry_d  = skid_carry;
      main_ovf_d    = skid_ovf;
    end else begin
      main_cmd_d    = in_cmd;
      main_result_d = in_result;
      main_zero_d   = cap_zero;
      main_carry_d  = cap_carry;
      main_ovf_d    = cap_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      sticky_q     <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= ~skid_valid_d;
      sticky_q     <= sticky_d;
    end
  end

  alu_stage_entry #(.WIDTH(WIDTH), .CMDW(CMDW)) u_main (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_main),
    .cmd_d    (main_cmd_d),
    .result_d (main_result_d),
    .zero_d   (main_zero_d),
    .carry_d  (main_carry_d),
    .ovf_d    (main_ovf_d),
    .cmd_q    (out_cmd),
    .result_q (out_result),
    .zero_q   (out_zero),
    .carry_q  (out_carryout),
    .ovf_q    (out_overflow)
  );

  alu_stage_entry #(.WIDTH(WIDTH), .CMDW(CMDW)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_skid),
    .cmd_d    (in_cmd),
    .result_d (in_result),
    .zero_d   (cap_zero),
    .carry_d  (cap_carry),
    .ovf_d    (cap_ovf),
    .cmd_q    (skid_cmd),
    .result_q (skid_result),
    .zero_q   (skid_zero),
    .carry_q  (skid_carry),
    .ovf_q    (skid_ovf)
  );

  assign out_valid  = main_valid_q;
  assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: vector table, backpressure, sticky overflow,
// random streaming and mid-stream reset, all scored against an expected queue.
module tb_alu_result_stage;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_cmd = '0;
  logic [W-1:0]  in_result = '0;
  logic          in_carryout = 1'b0;
  logic          in_overflow = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    out_cmd;
  logic [W-1:0]  out_result;
  logic          out_zero, out_carryout, out_overflow;
  logic          ovf_sticky;
  logic          ovf_clear = 1'b0;

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_result(in_result), .in_carryout(in_carryout), .in_overflow(in_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd),
    .out_result(out_result), .out_zero(out_zero), .out_carryout(out_carryout),
    .out_overflow(out_overflow), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
  );

  typedef struct {
    logic [2:0]   cmd;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [2:0]   cmd;
    logic [W-1:0] result;
    logic         c_in;
    logic         o_in;
    logic         zero;
    logic         carry;
    logic         ovf;
  } vec_t;

  exp_t  q[$];
  int    n_chk = 0;
  int    n_bad = 0;
  int    n_deliv = 0;
  logic  sb_sticky = 1'b0;
  logic  stall_prev = 1'b0;
  exp_t  held;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] cmd, input logic [W-1:0] res,
                                 input logic c, input logic o);
    exp_t e;
    logic adder;
    adder    = (cmd == 3'd0) || (cmd == 3'd1);
    e.cmd    = cmd;
    e.result = res;
    e.zero   = (res == 0);
    e.carry  = adder && c;
    e.ovf    = adder && o;
    return e;
  endfunction

  // Scoreboard: push on accept, pop on delivery, plus sticky and stall-stability tracking.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      sb_sticky  = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("sticky", ovf_sticky, sb_sticky);
      if (stall_prev) begin
        check("stall_result", out_result, held.result);
        check("stall_cmd", out_cmd, held.cmd);
      end
      if (in_valid && in_ready) q.push_back(model(in_cmd, in_result, in_carryout, in_overflow));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_chk++; n_bad++;
          $display("FAIL deliver_unexpected: got result 0x%0h expected none", out_result);
        end else begin
          e = q.pop_front();
          check("out_cmd", out_cmd, e.cmd);
          check("out_result", out_result, e.result);
          check("out_zero", out_zero, e.zero);
          check("out_carryout", out_carryout, e.carry);
          check("out_overflow", out_overflow, e.ovf);
          n_deliv++;
          if (e.ovf) sb_sticky = 1'b1;
          else if (ovf_clear) sb_sticky = 1'b0;
        end
      end else if (ovf_clear) begin
        sb_sticky = 1'b0;
      end
      stall_prev    = out_valid && !out_ready;
      held.cmd      = out_cmd;
      held.result   = out_result;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive one transfer, hold until accepted (bounded), return #1 after the accept edge.
  task automatic push_one(input logic [2:0] cmd, input logic [W-1:0] res,
                          input logic c, input logic o);
    logic ok;
    int   budget;
    in_cmd = cmd; in_result = res; in_carryout = c; in_overflow = o;
    in_valid = 1'b1;
    budget = 0;
    do begin
      @(negedge clk); ok = in_ready;
      step();
      budget++;
    end while (!ok && budget < 200);
    if (!ok) begin
      n_chk++; n_bad++;
      $display("FAIL push_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    int   base;
    int   sent;
    int   budget;
    logic acc;

    vecs[0] = '{3'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{3'd6, 32'hFFFF_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'd2, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3'd3, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{3'd4, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{3'd1, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{3'd7, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{3'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_result", out_result, 0);
    check("rst_sticky", ovf_sticky, 0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Table vectors, out_ready held high: each shows up the cycle after accept
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_one(vecs[i].cmd, vecs[i].result, vecs[i].c_in, vecs[i].o_in);
      check("tbl_out_valid", out_valid, 1);
      check("tbl_in_ready", in_ready, 1);
      check("tbl_zero", out_zero, vecs[i].zero);
      check("tbl_carry", out_carryout, vecs[i].carry);
      check("tbl_ovf", out_overflow, vecs[i].ovf);
    end
    step();
    check("tbl_drained", out_valid, 0);
    check("tbl_sticky", ovf_sticky, 0);

    // Sticky overflow: set, set-beats-clear, clear alone
    push_one(3'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    step();
    check("sticky_set", ovf_sticky, 1);
    out_ready = 1'b0;
    push_one(3'd1, 32'h8000_0001, 1'b1, 1'b1);
    ovf_clear = 1'b1; out_ready = 1'b1;
    step();
    ovf_clear = 1'b0;
    check("sticky_set_wins", ovf_sticky, 1);
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    check("sticky_cleared", ovf_sticky, 0);

    // Backpressure: A to main, B to skid, C held off until drain
    out_ready = 1'b0;
    base = n_deliv;
    push_one(3'd2, 32'hAAAA_0001, 1'b0, 1'b0);
    check("bp_ready_after_A", in_ready, 1);
    push_one(3'd4, 32'hBBBB_0002, 1'b0, 1'b0);
    check("bp_ready_after_B", in_ready, 0);
    in_cmd = 3'd7; in_result = 32'hCCCC_0003; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_held_ready", in_ready, 0);
      check("bp_head_A", out_result, 32'hAAAA_0001);
    end
    out_ready = 1'b1;
    push_one(3'd7, 32'hCCCC_0003, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step();
    check("bp_delivered", n_deliv - base, 3);

    // Random streaming
    base = n_deliv; sent = 0; budget = 0;
    in_valid = 1'b0;
    while ((sent < 100 || q.size() != 0 || out_valid) && budget < 3000) begin
      @(negedge clk); acc = in_valid && in_ready;
      step();
      budget++;
      if (acc) begin sent++; in_valid = 1'b0; end
      if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
        in_cmd      = 3'($urandom_range(0, 7));
        in_result   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        in_carryout = 1'($urandom_range(0, 1));
        in_overflow = 1'($urandom_range(0, 1));
        in_valid    = 1'b1;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    check("rand_delivered", n_deliv - base, 100);
    check("rand_queue_empty", q.size(), 0);

    // Reset with both entries full
    ovf_clear = 1'b1; out_ready = 1'b1; step(); ovf_clear = 1'b0;
    out_ready = 1'b0;
    push_one(3'd0, 32'hDEAD_0001, 1'b1, 1'b1);
    push_one(3'd1, 32'hDEAD_0002, 1'b1, 1'b1);
    check("full_out_valid", out_valid, 1);
    check("full_in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    check("rst_in_ready_comb", in_ready, 0);
    step();
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_cmd", out_cmd, 0);
    check("mid_rst_zero", out_zero, 0);
    check("mid_rst_carry", out_carryout, 0);
    check("mid_rst_ovf", out_overflow, 0);
    check("mid_rst_sticky", ovf_sticky, 0);
    check("mid_rst_in_ready", in_ready, 0);
    step();
    check("mid_rst_in_ready2", in_ready, 0);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_rst_no_old", out_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
